// File: rtl/text_console_writer.sv
// Write-side controller for the 80x60 text character RAM: byte stream in, cursor-addressed RAM writes out.
// Optional macro TEXT_CONSOLE_ROW_CLEAR_EN blanks each destination row on every row advance.
module text_console_writer #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 60,
    parameter int         ADDR_W = 13,
    parameter logic [6:0] BLANK  = 7'd32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    output logic [6:0]        ram_data,
    output logic [6:0]        cursor_col,
    output logic [5:0]        cursor_row,
    output logic              busy
);

    localparam logic [1:0] INIT_CLR = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] FULL_CLR = 2'd2;
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
    localparam logic [1:0] ROW_CLR  = 2'd3;
    localparam logic [ADDR_W-1:0] ROW_CLR_LAST = ADDR_W'(COLS - 1);
`endif

    localparam logic [ADDR_W-1:0] CLR_END  = ADDR_W'(COLS * ROWS);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
    localparam logic [5:0]        ROW_LAST = 6'(ROWS - 1);

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] clr_cnt_q,   clr_cnt_d;
    logic [6:0]        col_q,       col_d;
    logic [5:0]        row_q,       row_d;
    logic [ADDR_W-1:0] row_base_q,  row_base_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic              ram_wr_en_q, ram_wr_en_d;
    logic [6:0]        ram_data_q,  ram_data_d;

    logic              is_print_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [5:0]        next_row_s;
    logic [ADDR_W-1:0] next_base_s;

    // row_base tracks row*COLS so the cursor address needs only an adder
    assign is_print_s  = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign wr_addr_s   = row_base_q + ADDR_W'(col_q);
    assign next_row_s  = (row_q == ROW_LAST) ? 6'd0 : (row_q + 6'd1);
    assign next_base_s = (row_q == ROW_LAST) ? {ADDR_W{1'b0}} : (row_base_q + COLS_A);

    // Next-state, cursor and RAM write-port computation
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        row_base_d  = row_base_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_en_d = 1'b0;
        ram_data_d  = ram_data_q;
        case (state_q)
            INIT_CLR, FULL_CLR: begin
                // counter reaching the screen size marks the cycle after the last write
                if (clr_cnt_q == CLR_END) begin
                    state_d   = IDLE;
                    clr_cnt_d = {ADDR_W{1'b0}};
                end else begin
                    ram_wr_en_d = 1'b1;
                    ram_addr_d  = clr_cnt_q;
                    ram_data_d  = BLANK;
                    clr_cnt_d   = clr_cnt_q + ADDR_ONE;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    if (is_print_s) begin
                        ram_wr_en_d = 1'b1;
                        ram_addr_d  = wr_addr_s;
                        ram_data_d  = in_data[6:0];
                        if (col_q == COL_LAST) begin
                            col_d      = 7'd0;
                            row_d      = next_row_s;
                            row_base_d = next_base_s;
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
                            state_d    = ROW_CLR;
                            clr_cnt_d  = {ADDR_W{1'b0}};
`endif
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (in_data)
                            8'h0D: col_d = 7'd0;
                            8'h0A: begin
                                col_d      = 7'd0;
                                row_d      = next_row_s;
                                row_base_d = next_base_s;
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
                                state_d    = ROW_CLR;
                                clr_cnt_d  = {ADDR_W{1'b0}};
`endif
                            end
                            8'h08: begin
                                if (col_q != 7'd0) begin
                                    col_d       = col_q - 7'd1;
                                    ram_wr_en_d = 1'b1;
                                    ram_addr_d  = wr_addr_s - ADDR_ONE;
                                    ram_data_d  = BLANK;
                                end else begin
                                    col_d = col_q;
                                end
                            end
                            8'h0C: begin
                                // address 0 goes out with the FF itself so the clear spans exactly COLS*ROWS cycles
                                state_d     = FULL_CLR;
                                col_d       = 7'd0;
                                row_d       = 6'd0;
                                row_base_d  = {ADDR_W{1'b0}};
                                ram_wr_en_d = 1'b1;
                                ram_addr_d  = {ADDR_W{1'b0}};
                                ram_data_d  = BLANK;
                                clr_cnt_d   = ADDR_ONE;
                            end
                            default: col_d = col_q;
                        endcase
                    end
                end else begin
                    col_d = col_q;
                end
            end
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
            ROW_CLR: begin
                ram_wr_en_d = 1'b1;
                ram_addr_d  = row_base_q + clr_cnt_q;
                ram_data_d  = BLANK;
                if (clr_cnt_q == ROW_CLR_LAST) begin
                    state_d   = IDLE;
                    clr_cnt_d = {ADDR_W{1'b0}};
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_ONE;
                end
            end
`endif
            default: begin
                state_d   = INIT_CLR;
                clr_cnt_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_CLR;
            clr_cnt_q   <= {ADDR_W{1'b0}};
            col_q       <= 7'd0;
            row_q       <= 6'd0;
            row_base_q  <= {ADDR_W{1'b0}};
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_wr_en_q <= 1'b0;
            ram_data_q  <= 7'd0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_base_q  <= row_base_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_en_q <= ram_wr_en_d;
            ram_data_q  <= ram_data_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign ram_addr   = ram_addr_q;
    assign ram_wr_en  = ram_wr_en_q;
    assign ram_data   = ram_data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: vector table, corner sequences, random bytes vs. a screen model.
module tb_text_console_writer;

    localparam int COLS = 80;
    localparam int ROWS = 60;
    localparam int SCR  = COLS * ROWS;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [12:0] ram_addr;
    logic        ram_wr_en;
    logic [6:0]  ram_data;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    text_console_writer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_data(ram_data),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [6:0] dut_mem [SCR];
    logic [6:0] mem_m   [SCR];
    int col_m = 0;
    int row_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // image of the character RAM as seen through the write port
    always @(posedge clk) if (ram_wr_en && int'(ram_addr) < SCR) dut_mem[int'(ram_addr)] <= ram_data;

    typedef struct {
        logic [7:0]  din;
        logic        wr;
        logic [12:0] addr;
        logic [6:0]  data;
        logic [6:0]  col;
        logic [5:0]  row;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 6000) begin
            tick();
            n++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic expect_clear(input string name);
        for (int i = 0; i < SCR; i++) begin
            check(name, {ram_wr_en, in_ready, busy, ram_data, ram_addr},
                  {1'b1, 1'b0, 1'b1, 7'd32, 13'(i)});
            tick();
        end
        check({name, "_done"}, {ram_wr_en, in_ready, busy, cursor_col, cursor_row},
              {1'b0, 1'b1, 1'b0, 7'd0, 6'd0});
    endtask

    task automatic count_busy(input string name, input int exp);
        int n = 0;
        while (!in_ready && n < 6000) begin
            n++;
            tick();
        end
        check(name, n, exp);
    endtask

    task automatic model_advance();
        row_m = (row_m + 1) % ROWS;
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
        for (int c = 0; c < COLS; c++) mem_m[row_m * COLS + c] = 7'd32;
`endif
    endtask

    task automatic model_byte(input logic [7:0] b, output logic ew, output logic [12:0] ea,
                              output logic [6:0] ed);
        ew = 1'b0;
        ea = 13'd0;
        ed = 7'd0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            ew = 1'b1;
            ea = 13'(row_m * COLS + col_m);
            ed = b[6:0];
            mem_m[row_m * COLS + col_m] = b[6:0];
            if (col_m == COLS - 1) begin
                col_m = 0;
                model_advance();
            end else begin
                col_m++;
            end
        end else if (b == 8'h0D) begin
            col_m = 0;
        end else if (b == 8'h0A) begin
            col_m = 0;
            model_advance();
        end else if (b == 8'h08) begin
            if (col_m > 0) begin
                col_m--;
                ew = 1'b1;
                ea = 13'(row_m * COLS + col_m);
                ed = 7'd32;
                mem_m[row_m * COLS + col_m] = 7'd32;
            end
        end else if (b == 8'h0C) begin
            col_m = 0;
            row_m = 0;
            ew = 1'b1;
            ea = 13'd0;
            ed = 7'd32;
            for (int i = 0; i < SCR; i++) mem_m[i] = 7'd32;
        end
    endtask

    initial begin
        logic        ew;
        logic [12:0] ea;
        logic [6:0]  ed;
        logic [7:0]  b;
        int          c0;
        int          bad;
        int          n;
        int          r;

        tbl[0]  = '{8'h41, 1'b1, 13'd0,   7'h41, 7'd1, 6'd0};
        tbl[1]  = '{8'h42, 1'b1, 13'd1,   7'h42, 7'd2, 6'd0};
        tbl[2]  = '{8'h07, 1'b0, 13'd0,   7'h00, 7'd2, 6'd0};
        tbl[3]  = '{8'h0D, 1'b0, 13'd0,   7'h00, 7'd0, 6'd0};
        tbl[4]  = '{8'h08, 1'b0, 13'd0,   7'h00, 7'd0, 6'd0};
        tbl[5]  = '{8'h0A, 1'b0, 13'd0,   7'h00, 7'd0, 6'd1};
        tbl[6]  = '{8'h0A, 1'b0, 13'd0,   7'h00, 7'd0, 6'd2};
        tbl[7]  = '{8'h61, 1'b1, 13'd160, 7'h61, 7'd1, 6'd2};
        tbl[8]  = '{8'h62, 1'b1, 13'd161, 7'h62, 7'd2, 6'd2};
        tbl[9]  = '{8'h63, 1'b1, 13'd162, 7'h63, 7'd3, 6'd2};
        tbl[10] = '{8'h08, 1'b1, 13'd162, 7'h20, 7'd2, 6'd2};
        tbl[11] = '{8'h9B, 1'b0, 13'd0,   7'h00, 7'd2, 6'd2};
        tbl[12] = '{8'hFF, 1'b0, 13'd0,   7'h00, 7'd2, 6'd2};
        tbl[13] = '{8'h7E, 1'b1, 13'd162, 7'h7E, 7'd3, 6'd2};
        tbl[14] = '{8'h7F, 1'b0, 13'd0,   7'h00, 7'd3, 6'd2};
        tbl[15] = '{8'h20, 1'b1, 13'd163, 7'h20, 7'd4, 6'd2};
        tbl[16] = '{8'h1F, 1'b0, 13'd0,   7'h00, 7'd4, 6'd2};
        tbl[17] = '{8'h0A, 1'b0, 13'd0,   7'h00, 7'd0, 6'd3};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick(); tick(); tick();
        check("reset_state", {ram_wr_en, ram_addr, ram_data, cursor_col, cursor_row, in_ready, busy},
              {1'b0, 13'd0, 7'd0, 7'd0, 6'd0, 1'b0, 1'b1});
        rst = 1'b0;
        tick();
        expect_clear("init_clr");

        for (int i = 0; i < 18; i++) begin
            send_byte(tbl[i].din);
            check($sformatf("tbl%0d_wr", i), {31'd0, ram_wr_en}, {31'd0, tbl[i].wr});
            if (tbl[i].wr) check($sformatf("tbl%0d_wdata", i), {ram_addr, ram_data}, {tbl[i].addr, tbl[i].data});
            check($sformatf("tbl%0d_cursor", i), {cursor_col, cursor_row}, {tbl[i].col, tbl[i].row});
        end

        // 81 printable bytes from (0,3) wrap into row 4
        c0 = cyc;
        for (int i = 0; i < 80; i++) begin
            send_byte(8'h78);
            check("wrap_wr", {ram_wr_en, ram_addr, ram_data}, {1'b1, 13'(240 + i), 7'h78});
            check("wrap_cursor", {cursor_col, cursor_row}, {7'((241 + i) % COLS), 6'((241 + i) / COLS)});
        end
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
        count_busy("wrap_rowclr_cycles", 80);
`endif
        send_byte(8'h78);
        check("wrap81_wr", {ram_wr_en, ram_addr, ram_data}, {1'b1, 13'd320, 7'h78});
        check("wrap81_cursor", {cursor_col, cursor_row}, {7'd1, 6'd4});
`ifndef TEXT_CONSOLE_ROW_CLEAR_EN
        check("wrap_throughput", cyc - c0, 81);
`endif

        for (int i = 0; i < 55; i++) send_byte(8'h0A);
        check("lf_to_bottom", {cursor_col, cursor_row}, {7'd0, 6'd59});
        for (int j = 0; j < 5; j++) begin
            send_byte(8'h79);
            check("bottom_wr", {ram_wr_en, ram_addr}, {1'b1, 13'(4720 + j)});
        end
        check("bottom_cursor", {cursor_col, cursor_row}, {7'd5, 6'd59});
        send_byte(8'h0A);
        check("bottom_lf", {ram_wr_en, cursor_col, cursor_row}, {1'b0, 7'd0, 6'd0});
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
        count_busy("bottom_rowclr_cycles", 80);
        tick();
        bad = 0;
        for (int i = 0; i < COLS; i++) if (dut_mem[i] !== 7'd32) bad++;
        check("bottom_row0_blank", bad, 0);
`endif
        send_byte(8'h5A);
        check("bottom_base0", {ram_wr_en, ram_addr, ram_data, cursor_col, cursor_row},
              {1'b1, 13'd0, 7'h5A, 7'd1, 6'd0});

        send_byte(8'h0C);
        check("ff_accept", {ram_wr_en, ram_addr, in_ready, busy, cursor_col, cursor_row},
              {1'b1, 13'd0, 1'b0, 1'b1, 7'd0, 6'd0});
        expect_clear("ff_clr");
        bad = 0;
        for (int i = 0; i < SCR; i++) if (dut_mem[i] !== 7'd32) bad++;
        check("ff_screen_blank", bad, 0);

        // reset in the middle of a clear restarts the whole initial clear
        send_byte(8'h0C);
        n = 0;
        while (!(ram_wr_en && ram_addr == 13'd1000) && n < 2000) begin
            tick();
            n++;
        end
        check("reach_addr_1000", {ram_wr_en, ram_addr}, {1'b1, 13'd1000});
        rst = 1'b1;
        tick();
        check("midclr_reset", {ram_wr_en, ram_addr, ram_data, cursor_col, cursor_row, in_ready, busy},
              {1'b0, 13'd0, 7'd0, 7'd0, 6'd0, 1'b0, 1'b1});
        rst = 1'b0;
        tick();
        expect_clear("restart_clr");

        for (int i = 0; i < SCR; i++) mem_m[i] = 7'd32;
        col_m = 0;
        row_m = 0;
        for (int k = 0; k < 2000; k++) begin
            if (in_ready && $urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
                check("idle_gap", {ram_wr_en, cursor_col, cursor_row}, {1'b0, 7'(col_m), 6'(row_m)});
            end
            r = $urandom_range(0, 99);
            if (r < 60)      b = 8'($urandom_range(32, 126));
            else if (r < 68) b = 8'h0D;
            else if (r < 78) b = 8'h0A;
            else if (r < 88) b = 8'h08;
            else             b = 8'($urandom_range(0, 255));
            model_byte(b, ew, ea, ed);
            send_byte(b);
            if (ew) check("rnd_wr", {ram_wr_en, ram_addr, ram_data}, {1'b1, ea, ed});
            else    check("rnd_nowr", {31'd0, ram_wr_en}, 32'd0);
            check("rnd_cursor", {cursor_col, cursor_row}, {7'(col_m), 6'(row_m)});
        end
        n = 0;
        while (!in_ready && n < 6000) begin
            tick();
            n++;
        end
        check("drain", {31'd0, in_ready}, 32'd1);
        tick();
        bad = 0;
        for (int i = 0; i < SCR; i++) if (dut_mem[i] !== mem_m[i]) bad++;
        check("screen_image", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Write-side controller for the 80x60 text character RAM. It accepts a stream of ASCII bytes over a valid/ready handshake and keeps a cursor. Printable characters are written into the RAM write port at the cursor position. Control codes (CR, LF, BS, FF) move the cursor or clear the screen. It sits between the host or text source and the character RAM, whose read port is consumed by the VGA text renderer.

## Interface
Parameters:
- `COLS`, 80, characters per row
- `ROWS`, 60, rows per screen
- `ADDR_W`, 13, RAM address width (must satisfy COLS*ROWS <= 2^ADDR_W)
- `BLANK`, 7'd32, fill character (ASCII space)

Ports:
- `clk`  in  1  single clock; also drives the RAM write port
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input byte valid
- `in_data`  in  8  input byte
- `in_ready`  out  1  byte accepted on a cycle where in_valid & in_ready
- `ram_addr`  out  ADDR_W  RAM write address (registered)
- `ram_wr_en`  out  1  RAM write enable (registered)
- `ram_data`  out  7  RAM write data (registered)
- `cursor_col`  out  7  current column, 0..COLS-1
- `cursor_row`  out  6  current row, 0..ROWS-1
- `busy`  out  1  high in any clear state

## Operation
- States:
  - `INIT_CLR`: entered on reset.
  - `IDLE`
  - `FULL_CLR`: entered on FF.
  - `ROW_CLR`: exists only with the macro.
- `in_ready` = (state == IDLE); it is a combinational decode of the state register.
- Address generation uses no multiplier:
  - A `row_base` register holds row*COLS. It is incremented by COLS on row advance and reset to 0 on wrap.
  - Write address = row_base + col.
- Accepted byte handling in IDLE:
  - 0x20..0x7E: write in_data[6:0] at the cursor, then advance col. At col == COLS-1, perform a row advance instead of incrementing col.
  - 0x0D (CR): col ← 0; no write.
  - 0x0A (LF): col ← 0 and row advance; no write.
  - 0x08 (BS):
    - If col > 0: col ← col-1 and write BLANK at the new position.
    - If col == 0: no change, no write.
  - 0x0C (FF): enter FULL_CLR; cursor ← (0,0).
  - All other bytes, including bit 7 set: consumed, with no write and no cursor change.
- Row advance:
  - row ← row+1, or row ← 0 (with row_base ← 0) when row == ROWS-1.
  - Without the macro, the state stays IDLE.
- INIT_CLR and FULL_CLR:
  - Write BLANK to addresses 0..COLS*ROWS-1 (0..4799), one per cycle, ascending.
  - Return to IDLE the cycle after the last write.
- Clear progress is tracked with a counter of ADDR_W bits. Cursor values never exceed COLS-1 / ROWS-1.

## Timing
- Reset values:
  - ram_wr_en=0, ram_addr=0, ram_data=0
  - cursor_col=0, cursor_row=0
  - in_ready=0, busy=1
  - state=INIT_CLR, clear counter=0
- Initial clear after reset:
  - The first clear write (addr 0) is presented on the first edge with rst low.
  - 4800 consecutive write cycles follow.
  - in_ready rises in the cycle after addr 4799 is presented, and busy falls in the same cycle.
- Write latency: a byte accepted at edge N has ram_wr_en/ram_addr/ram_data valid after edge N, i.e. during cycle N+1. The cursor outputs update at the same edge.
- Throughput: one byte per cycle in IDLE, including back-to-back printable bytes across a row wrap.
- ram_wr_en is high for exactly one cycle per write; it is otherwise 0.
- FF accepted at edge N: the clear writes occupy cycles N+1..N+4800 and in_ready=0 throughout.
- rst asserted mid-operation (including mid-clear): the next edge applies the reset values and the full initial clear restarts from addr 0.
- in_data is ignored whenever in_ready=0; the source must hold in_valid/in_data until it is accepted.

## Configuration
- Macro: `TEXT_CONSOLE_ROW_CLEAR_EN`.
- Defined:
  - Every row advance (wrap at col COLS-1, LF, or wrap from row ROWS-1 to 0) enters ROW_CLR.
  - ROW_CLR writes BLANK to row_base..row_base+COLS-1 of the destination row, one address per cycle for 80 cycles.
  - in_ready=0 and busy=1 during ROW_CLR.
  - Return to IDLE with the cursor at (0, new row).
- Undefined:
  - ROW_CLR does not exist, and a row advance costs no extra cycles.
  - Old row contents persist until overwritten.

## Test plan
- Reset, hold 3 cycles, release: 4800 writes of 32 to addrs 0..4799 with no gaps; in_ready rises one cycle later; cursor=(0,0).
- Send 'A','B' back-to-back: writes 0x41@0 and 0x42@1 on consecutive cycles; cursor=(2,0).
- Row wrap:
  - Send 81 × 'x': the 81st write lands at addr 80 and cursor=(1,1).
  - With the macro: addrs 80..159 are cleared to 32 before the 81st byte is accepted, and in_ready is low for 80 cycles.
- Bottom wrap:
  - Cursor at (5,59), send LF: cursor=(0,0) and row_base=0.
  - With the macro: addrs 0..79 are written 32.
- Control codes:
  - BS at col 0: no write, cursor unchanged.
  - BS at (3,2): writes 32@162, cursor=(2,2).
  - Byte 0x07: consumed, no write.
- FF mid-stream: in_ready low for exactly 4800 cycles, then cursor=(0,0). Assert rst at clear write 1000: the clear restarts at addr 0 and completes the full 4800.
